fpu_rr_arbiter: RTL and testbench

//  Shares one pipelined FP16 FPU (operands A/B, 2-bit opcode, result O, fixed

---
 rtl/fpu_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpu_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined FP16 FPU between NREQ requesters.
// Optional per-requester in-flight limit: define FPU_ARB_CREDIT_EN.
module fpu_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int FPU_LAT = 3,
    parameter int MAX_OUT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*2-1:0]       req_op,
    output logic [WIDTH-1:0]        fpu_a,
    output logic [WIDTH-1:0]        fpu_b,
    output logic [1:0]              fpu_op,
    input  logic [WIDTH-1:0]        fpu_o,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_data
);

    localparam int IDW = $clog2(NREQ);
    localparam int IW  = IDW + 1;

    if (NREQ < 2 || FPU_LAT < 1 || MAX_OUT < 1) begin : g_param_check
        $error("fpu_rr_arbiter: illegal parameter values");
    end

    logic [IDW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]            fpu_a_q, fpu_a_d;
    logic [WIDTH-1:0]            fpu_b_q, fpu_b_d;
    logic [1:0]                  fpu_op_q, fpu_op_d;
    logic [FPU_LAT:0]            tv_q, tv_d;
    logic [FPU_LAT:0][IDW-1:0]   tid_q, tid_d;
    logic [NREQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]            rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]             elig;
    logic [NREQ-1:0]             gnt;
    logic [IDW-1:0]              gnt_id;
    logic                        found;
    logic                        issue;
    logic [IW-1:0]               idx;

`ifdef FPU_ARB_CREDIT_EN
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [NREQ-1:0][CW-1:0]     cnt_q, cnt_d;

    // A requester at its in-flight limit is invisible to the scan.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NREQ; k++) begin
            elig[k] = req_valid[k] && (cnt_q[k] != CW'(MAX_OUT));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NREQ; k++) begin
            cnt_d[k] = cnt_q[k] + CW'(req_ready[k]) - CW'(rsp_valid_q[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        elig = req_valid;
    end
`endif

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'(rr_ptr_q) + IW'(i);
            if (idx >= IW'(NREQ)) begin
                idx = idx - IW'(NREQ);
            end
            if (!found && elig[idx[IDW-1:0]]) begin
                found  = 1'b1;
                gnt_id = idx[IDW-1:0];
            end
        end
        issue = found && !rst;
        gnt   = issue ? (NREQ'(1) << gnt_id) : '0;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        fpu_a_d  = fpu_a_q;
        fpu_b_d  = fpu_b_q;
        fpu_op_d = fpu_op_q;
        if (issue) begin
            rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            fpu_a_d  = req_a[int'(gnt_id)*WIDTH +: WIDTH];
            fpu_b_d  = req_b[int'(gnt_id)*WIDTH +: WIDTH];
            fpu_op_d = req_op[int'(gnt_id)*2 +: 2];
        end
    end

    // Stage 0 lines up with the FPU input register; the last stage
    // lines up with fpu_o.
    always_comb begin
        tv_d  = {tv_q[FPU_LAT-1:0], issue};
        tid_d = {tid_q[FPU_LAT-1:0], gnt_id};
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tv_q[FPU_LAT]) begin
            rsp_valid_d = NREQ'(1) << tid_q[FPU_LAT];
            rsp_data_d  = fpu_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= '0;
            tv_q        <= '0;
            tid_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            tv_q        <= tv_d;
            tid_q       <= tid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = gnt;
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_op    = fpu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Bench for fpu_rr_arbiter: FPU model on the fpu_* side, scoreboard of
// expected responses, reference round-robin model for grants.
module tb_fpu_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int L  = 3;
    localparam int MO = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*2-1:0] req_op;
    logic [W-1:0]   fpu_a;
    logic [W-1:0]   fpu_b;
    logic [1:0]     fpu_op;
    logic [W-1:0]   fpu_o;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;

    fpu_rr_arbiter #(.NREQ(N), .WIDTH(W), .FPU_LAT(L), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_o(fpu_o),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // FP16 add for positive normals; other opcodes give a distinct mix.
    function automatic logic [15:0] fpu_fn(logic [15:0] a, logic [15:0] b,
                                           logic [1:0] op);
        logic [4:0]  xa, xb, xt;
        logic [10:0] ma, mb, mt;
        logic [11:0] s;
        if (op != 2'b00) return {op, a[13:0] ^ b[13:0]};
        xa = a[14:10]; xb = b[14:10];
        ma = {1'b1, a[9:0]}; mb = {1'b1, b[9:0]};
        if (xa < xb) begin
            xt = xa; xa = xb; xb = xt;
            mt = ma; ma = mb; mb = mt;
        end
        mb = mb >> (xa - xb);
        s  = {1'b0, ma} + {1'b0, mb};
        if (s[11]) return {1'b0, xa + 5'd1, s[10:1]};
        return {1'b0, xa, s[9:0]};
    endfunction

    logic [W-1:0] pipe [1:L];
    always @(posedge clk) begin
        pipe[1] <= fpu_fn(fpu_a, fpu_b, fpu_op);
        for (int k = 2; k <= L; k++) pipe[k] <= pipe[k-1];
    end
    assign fpu_o = pipe[L];

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sbq[$];
    int           nasserts = 0;
    int           nfail    = 0;
    int           cyc      = 0;
    int           ptr      = 0;
    int           cnt[N];
    logic [W-1:0] ea, eb;
    logic [1:0]   eop;
    logic [15:0]  tbl[4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nasserts++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_req(int k, logic [15:0] a, logic [15:0] b,
                           logic [1:0] op);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
        req_op[k*2 +: 2] = op;
    endtask

    function automatic bit has_credit(int k);
`ifdef FPU_ARB_CREDIT_EN
        return cnt[k] < MO;
`else
        return (k >= 0);
`endif
    endfunction

    // One clock: called at a negedge with inputs already driven.
    task automatic step();
        logic [N-1:0] eg, er;
        int gid, ix;
        exp_t e;
        #1;
        eg = '0; er = '0; gid = -1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                ix = (ptr + i) % N;
                if (gid < 0 && req_valid[ix] && has_credit(ix)) gid = ix;
            end
        end
        if (gid >= 0) eg[gid] = 1'b1;
        chk("grant", req_ready, eg);
        chk("fpu_a", fpu_a, ea);
        chk("fpu_b", fpu_b, eb);
        chk("fpu_op", fpu_op, eop);
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            er[e.id] = 1'b1;
            chk("rsp_data", rsp_data, e.data);
        end
        chk("rsp_valid", rsp_valid, er);
        if (gid >= 0) begin
            sbq.push_back('{due: cyc + L + 2, id: gid,
                data: fpu_fn(req_a[gid*W +: W], req_b[gid*W +: W],
                             req_op[gid*2 +: 2])});
        end
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < N; k++) cnt[k] += int'(eg[k]) - int'(er[k]);
            if (gid >= 0) begin
                ptr = (gid + 1) % N;
                ea  = req_a[gid*W +: W];
                eb  = req_b[gid*W +: W];
                eop = req_op[gid*2 +: 2];
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_b", fpu_b, 0);
        chk("rst_fpu_op", fpu_op, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        sbq.delete();
        ptr = 0; ea = '0; eb = '0; eop = '0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        req_valid = '0;
        while (sbq.size() > 0 && g < 40) begin
            step();
            g++;
        end
        chk("drain_left", sbq.size(), 0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        ea = '0; eb = '0; eop = '0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        @(negedge clk);
        do_reset();

        // single request: 1.0 + 2.0 = 3.0 from requester 1
        set_req(1, 16'h3C00, 16'h4000, 2'b00);
        req_valid = 4'b0010;
        step();
        drain();

        // idle: pointer must hold at 2
        for (int i = 0; i < 10; i++) step();
        for (int k = 0; k < N; k++) set_req(k, tbl[k], tbl[(k+1)%4], 2'b00);
        req_valid = 4'b1111;
        step();
        drain();

        // contention from reset
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, tbl[k], tbl[3-k], 2'(k));
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) step();
        drain();

        // wrap/skip: pointer at 3, only 0 and 2 valid
        do_reset();
        set_req(0, 16'h4000, 16'h4000, 2'b00);
        set_req(2, 16'h4200, 16'h3C00, 2'b01);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0101;
        for (int i = 0; i < 3; i++) step();
        drain();

        // reset with three ops in flight
        for (int k = 0; k < 3; k++) set_req(k, tbl[k], tbl[k+1], 2'b00);
        req_valid = 4'b0001; step();
        req_valid = 4'b0010; step();
        req_valid = 4'b0100; step();
        req_valid = '0;
        do_reset();
        for (int i = 0; i < L + 4; i++) step();

        // random traffic
        for (int i = 0; i < 40; i++) begin
            req_valid = 4'($urandom);
            for (int k = 0; k < N; k++)
                set_req(k, tbl[$urandom_range(0, 3)], tbl[$urandom_range(0, 3)],
                        2'($urandom));
            step();
        end
        drain();

`ifdef FPU_ARB_CREDIT_EN
        do_reset();
        set_req(0, 16'h3C00, 16'h3C00, 2'b00);
        req_valid = 4'b0001;
        for (int i = 0; i < 16; i++) step();
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasserts, nfail);
        $finish;
    end

endmodule
